// File: rtl/dot_product_pkg.sv
// Shared constants and word type for the sign-magnitude dot-product pipeline.
package dot_product_pkg;

    localparam int DP_W    = 19;
    localparam int DP_FRAC = 10;

    localparam int                SM_SIGN    = DP_W - 1;
    localparam logic [DP_W-2:0]   SM_MAG_MAX = {(DP_W-1){1'b1}};

    typedef struct packed {
        logic            sign;
        logic [DP_W-2:0] mag;
    } sm_word_t;

endpackage

// File: rtl/sm_adder.sv
// Combinational sign-magnitude adder with magnitude saturation and +0 normalisation.
module sm_adder
    import dot_product_pkg::*;
#(
    parameter int W = DP_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         sat
);

    // Returns {sat, sign, magnitude}; -0 inputs fall out naturally as zero magnitudes.
    function automatic logic [W:0] sm_add_sat(input logic [W-1:0] x, input logic [W-1:0] y);
        logic         sx, sy, sgn, s;
        logic [W-2:0] mx, my, mag;
        logic [W-1:0] wide;
        sx   = x[W-1];
        sy   = y[W-1];
        mx   = x[W-2:0];
        my   = y[W-2:0];
        s    = 1'b0;
        wide = '0;
        if (sx == sy) begin
            wide = {1'b0, mx} + {1'b0, my};
            s    = wide[W-1];
            mag  = s ? {(W-1){1'b1}} : wide[W-2:0];
            sgn  = sx;
        end else if (mx >= my) begin
            mag = mx - my;
            sgn = sx;
        end else begin
            mag = my - mx;
            sgn = sy;
        end
        if (mag == '0) sgn = 1'b0;
        return {s, sgn, mag};
    endfunction

    always_comb begin
        {sat, sum} = sm_add_sat(a, b);
    end

endmodule

// File: rtl/dot_product_stage_2.sv
// Reduces x/y/z sign-magnitude products to (x+y)+z over two registered adder stages.
// Optional overflow flag output enabled by defining DOT_PRODUCT_STAGE2_OVF_EN.
module dot_product_stage_2
    import dot_product_pkg::*;
#(
    parameter int W    = DP_W,
    parameter int FRAC = DP_FRAC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stage2_in_valid,
    output logic         stage2_in_ready,
    input  logic [W-1:0] stage2_in_x,
    input  logic [W-1:0] stage2_in_y,
    input  logic [W-1:0] stage2_in_z,
    output logic         stage2_out_valid,
    input  logic         stage2_out_ready,
`ifdef DOT_PRODUCT_STAGE2_OVF_EN
    output logic         stage2_out_ovf,
`endif
    output logic [W-1:0] stage2_out_dot
);

    if (FRAC > W - 1) begin : g_bad_frac
        $error("FRAC must fit inside the magnitude field");
    end

    logic         vld_p0, vld_p1;
    logic [W-1:0] sum_p0, z_p0, dot_p1;
    logic         ovf_p0, ovf_p1;
    logic [W-1:0] sum_a, sum_b;
    logic         sat_a, sat_b;
    logic         stall_b, load_a, load_b;

    sm_adder #(.W(W)) u_add_a (.a(stage2_in_x), .b(stage2_in_y), .sum(sum_a), .sat(sat_a));
    sm_adder #(.W(W)) u_add_b (.a(sum_p0),      .b(z_p0),        .sum(sum_b), .sat(sat_b));

    assign stall_b         = vld_p1 && !stage2_out_ready;
    assign load_b          = !stall_b;
    assign load_a          = !vld_p0 || !stall_b;
    assign stage2_in_ready = load_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            sum_p0 <= '0;
            z_p0   <= '0;
            ovf_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            dot_p1 <= '0;
            ovf_p1 <= 1'b0;
        end else begin
            // Stage A: x+y with z carried alongside
            if (load_a) begin
                vld_p0 <= stage2_in_valid;
                sum_p0 <= sum_a;
                z_p0   <= stage2_in_z;
                ovf_p0 <= sat_a;
            end
            // Stage B: (x+y)+z, the output register
            if (load_b) begin
                vld_p1 <= vld_p0;
                dot_p1 <= sum_b;
                ovf_p1 <= ovf_p0 | sat_b;
            end
        end
    end

    assign stage2_out_valid = vld_p1;
    assign stage2_out_dot   = dot_p1;

`ifdef DOT_PRODUCT_STAGE2_OVF_EN
    assign stage2_out_ovf = ovf_p1;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_p1;
`endif

endmodule

// File: tb/tb_dot_product_stage_2.sv
// Directed self-checking bench for dot_product_stage_2 (hand-computed expectations).
module tb_dot_product_stage_2;
    import dot_product_pkg::*;

    localparam int W = DP_W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_x = '0, in_y = '0, in_z = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_dot;
`ifdef DOT_PRODUCT_STAGE2_OVF_EN
    logic         out_ovf;
`endif

    int checks = 0;
    int errors = 0;

    dot_product_stage_2 dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stage2_in_valid  (in_valid),
        .stage2_in_ready  (in_ready),
        .stage2_in_x      (in_x),
        .stage2_in_y      (in_y),
        .stage2_in_z      (in_z),
        .stage2_out_valid (out_valid),
        .stage2_out_ready (out_ready),
`ifdef DOT_PRODUCT_STAGE2_OVF_EN
        .stage2_out_ovf   (out_ovf),
`endif
        .stage2_out_dot   (out_dot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // One isolated transaction with out_ready high; called at posedge+1.
    task automatic run_vec(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] z, input logic [W-1:0] exp, input logic exp_ovf);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_x = x; in_y = y; in_z = z;
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_dot"}, 32'(out_dot), 32'(exp));
`ifdef DOT_PRODUCT_STAGE2_OVF_EN
        chk({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("unexpected x in ovf expectation");
`endif
        @(posedge clk); #1;
        chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
    endtask

    logic [W-1:0] bp_x   [4] = '{19'h00001, 19'h00010, 19'h40100, 19'h00005};
    logic [W-1:0] bp_y   [4] = '{19'h00002, 19'h00020, 19'h40100, 19'h40007};
    logic [W-1:0] bp_z   [4] = '{19'h00003, 19'h40005, 19'h00300, 19'h00000};
    logic [W-1:0] bp_exp [4] = '{19'h00006, 19'h0002B, 19'h00100, 19'h40002};
    logic [W-1:0] exp_q  [$];

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent;
        int rcvd;
        logic [W-1:0] head;

        // Reset state
        #12;
        chk("rst_vld",   32'(out_valid), 32'd0);
        chk("rst_dot",   32'(out_dot),   32'd0);
        chk("rst_ready", 32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_vec("basic",    19'h00400, 19'h00800, 19'h40200, 19'h00A00, 1'b0);
        run_vec("pos_sat",  19'h3FFFF, 19'h00001, 19'h00000, 19'h3FFFF, 1'b1);
        run_vec("neg_sat",  19'h7FFFF, 19'h40001, 19'h00000, 19'h7FFFF, 1'b1);
        run_vec("b_sat",    19'h20000, 19'h10000, 19'h10000, 19'h3FFFF, 1'b1);
        run_vec("cancel",   19'h00400, 19'h40400, 19'h40000, 19'h00000, 1'b0);
        run_vec("negzero",  19'h40000, 19'h40000, 19'h40000, 19'h00000, 1'b0);
        run_vec("bigsign",  19'h00100, 19'h40300, 19'h00000, 19'h40200, 1'b0);

        // Backpressure: four back-to-back inputs, output held off for the first cycles
        sent = 0;
        rcvd = 0;
        for (int c = 0; c < 40 && rcvd < 4; c++) begin
            out_ready = (c >= 4);
            in_valid  = (sent < 4);
            if (sent < 4) begin
                in_x = bp_x[sent]; in_y = bp_y[sent]; in_z = bp_z[sent];
            end
            @(negedge clk);
            if (c == 2) begin
                chk("bp_ready_drop", 32'(in_ready),  32'd0);
                chk("bp_vld_stall",  32'(out_valid), 32'd1);
                chk("bp_dot_stall",  32'(out_dot),   32'(bp_exp[0]));
            end
            if (c == 3) begin
                chk("bp_ready_low", 32'(in_ready), 32'd0);
                chk("bp_dot_hold",  32'(out_dot),  32'(bp_exp[0]));
            end
            if (c == 4) chk("bp_ready_rise", 32'(in_ready), 32'd1);
            if (in_valid && in_ready) begin
                exp_q.push_back(bp_exp[sent]);
                sent++;
            end
            if (out_valid && out_ready) begin
                head = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                chk($sformatf("bp_out%0d", rcvd), 32'(out_dot), 32'(head));
                rcvd++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_count", 32'(rcvd), 32'd4);
        chk("bp_nodup", 32'(out_valid), 32'd0);

        // Reset with two results in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_x = 19'h00001; in_y = 19'h00001; in_z = 19'h00001;
        @(posedge clk); #1;
        in_x = 19'h00002;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_pre_vld", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld",   32'(out_valid), 32'd0);
        chk("mid_rst_dot",   32'(out_dot),   32'd0);
        chk("mid_rst_ready", 32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("mid_stale%0d", i), 32'(out_valid), 32'd0);
        end
        chk("mid_ready_after", 32'(in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
